block_averager: RTL

BLOCK_AVERAGER -- requirements
Module: block_averager

---
 rtl/block_averager.sv | 78 +++++++
 1 files changed

// File: rtl/block_averager.sv
// block_averager: streaming mean over blocks of 2^L signed samples
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   in_data/in_valid signed sample stream and its qualifier
//   enable          1 runs averaging, 0 aborts the current block and idles
//   log2_len        block length exponent, clamped to MAX_LOG2, latched per block
//   out_data        block mean (floor), held between results
//   out_valid       one-cycle pulse per new out_data
//   busy            high while accumulating
//   block_count     blocks emitted since reset, wrapping
module block_averager #(
    parameter int DATA_W   = 16,
    parameter int MAX_LOG2 = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    input  logic                     enable,
    input  logic [3:0]               log2_len,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     busy,
    output logic [31:0]              block_count
);
    localparam int AW = DATA_W + MAX_LOG2;
    localparam int CW = MAX_LOG2 + 1;
    localparam logic [3:0] MAXL = 4'(MAX_LOG2);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state_q, state_d;
    logic signed [AW-1:0] acc, sum;
    logic [CW-1:0]       cnt, last_idx;
    logic [3:0]          leff, lclamp;
    logic                accept, done;

    assign lclamp   = (log2_len > MAXL) ? MAXL : log2_len;
    assign sum      = acc + AW'(in_data);
    assign last_idx = (CW'(1) << leff) - CW'(1);
    assign busy     = (state_q == ACCUM);

    always_comb begin
        state_d = enable ? ACCUM : IDLE;
        accept  = (state_q == ACCUM) && enable && in_valid;
        done    = accept && (cnt == last_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            leff        <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            block_count <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= done;
            if (state_q == IDLE) begin
                // clearing every idle cycle means the entry edge starts a fresh block
                acc  <= '0;
                cnt  <= '0;
                leff <= lclamp;
            end else if (done) begin
                out_data    <= DATA_W'(sum >>> leff);
                block_count <= block_count + 32'd1;
                acc         <= '0;
                cnt         <= '0;
                leff        <= lclamp;
            end else if (accept) begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule
